// File: rtl/display_pkg.sv
// Shared types and constants for the display update queue: entry layout, FSM states,
// opcode constants and the WAIT_HI retry timeout.
package display_pkg;

    localparam int unsigned BlankW  = 1;
    localparam int unsigned OpcodeW = 3;
    localparam int unsigned RegIdxW = 4;
    localparam int unsigned ValueW  = 16;
    localparam int unsigned EntryW  = BlankW + OpcodeW + RegIdxW + ValueW;

    localparam logic [OpcodeW-1:0] OpClear = 3'b110;
    localparam logic [OpcodeW-1:0] OpDpl   = 3'b111;

    // Cycles from one start pulse to its retry when the controller never raises busy.
    localparam int unsigned WaitHiTimeout = 8;
    localparam int unsigned WaitHiTmrW    = $clog2(WaitHiTimeout);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo
    } state_e;

    typedef struct packed {
        logic [BlankW-1:0]  blank;
        logic [OpcodeW-1:0] opcode;
        logic [RegIdxW-1:0] reg_idx;
        logic [ValueW-1:0]  value;
    } entry_t;

endpackage

// File: rtl/display_update_queue_if.sv
// CPU-side request bus of the display update queue. The CPU is the master, the queue the slave.
interface display_update_queue_if;
    import display_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_blank;
    logic [OpcodeW-1:0] req_opcode;
    logic [RegIdxW-1:0] req_reg_idx;
    logic [ValueW-1:0]  req_value;

    modport master (
        output req_valid,
        output req_blank,
        output req_opcode,
        output req_reg_idx,
        output req_value,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_blank,
        input  req_opcode,
        input  req_reg_idx,
        input  req_value,
        output req_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count. Flush can optionally keep the head entry so a
// transfer already in flight can finish and pop it normally.
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             keep_head,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    // Flush beats a simultaneous push; a full queue refuses even if it pops this cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // Pointer and count next state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (flush) begin
            if (keep_head && !do_pop && !empty) begin
                wptr_d  = rptr_q + PtrW'(1);
                count_d = CntW'(1);
            end else begin
                wptr_d  = rptr_d;
                count_d = '0;
            end
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/display_update_queue.sv
// Display update queue: buffers CPU display updates and hands them one at a time to the LCD
// controller using a start pulse / busy handshake with retry on a missed start.
// Optional feature: define DISP_Q_SPLASH_EN to issue one splash request after reset.
module display_update_queue
    import display_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    display_update_queue_if.slave  req,
    input  logic                   flush,
    input  logic                   lcd_busy,
    output logic                   lcd_start_update,
    output logic                   lcd_mode_splash,
    output logic                   lcd_mode_blank,
    output logic [OpcodeW-1:0]     lcd_opcode,
    output logic [RegIdxW-1:0]     lcd_reg_idx,
    output logic [ValueW-1:0]      lcd_value,
    output logic [4:0]             q_count,
    output logic                   overflow
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_e                state_q, state_d;
    logic [WaitHiTmrW-1:0] tmr_q, tmr_d;
    logic                  overflow_q;
    entry_t                wr_entry;
    entry_t                head;
    logic [CntW-1:0]       count;
    logic                  full;
    logic                  empty;
    logic                  xfer_done;
    logic                  pop;
    logic                  keep_head;
    logic                  splash_active;

    assign wr_entry      = {req.req_blank, req.req_opcode, req.req_reg_idx, req.req_value};
    assign req.req_ready = !full;
    assign q_count       = 5'(count);
    assign overflow      = overflow_q;
    assign xfer_done     = (state_q == StWaitLo) && !lcd_busy;
    // The splash transfer occupies no FIFO slot, so it neither pops nor protects the head.
    assign pop           = xfer_done && !splash_active;
    assign keep_head     = (state_q != StIdle) && !splash_active;

`ifdef DISP_Q_SPLASH_EN
    logic splash_pending_q;

    // Splash stays pending from reset until its own transfer completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            splash_pending_q <= 1'b1;
        end else if (xfer_done) begin
            splash_pending_q <= 1'b0;
        end
    end

    assign splash_active = splash_pending_q;
`else
    assign splash_active = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req.req_valid),
        .pop       (pop),
        .flush     (flush),
        .keep_head (keep_head),
        .wdata     (wr_entry),
        .rdata     (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Sticky overflow: a request refused because the queue was full (flush cycles excluded).
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (req.req_valid && full && !flush) begin
            overflow_q <= 1'b1;
        end
    end

    // FSM state and retry timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // FSM next state; WAIT_HI retries so the re-pulse lands WaitHiTimeout cycles after the last.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            StIdle: begin
                if ((!empty || splash_active) && !lcd_busy) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitHi;
                tmr_d   = '0;
            end
            StWaitHi: begin
                if (lcd_busy) begin
                    state_d = StWaitLo;
                end else if (tmr_q == WaitHiTmrW'(WaitHiTimeout - 2)) begin
                    state_d = StIssue;
                end else begin
                    tmr_d = tmr_q + WaitHiTmrW'(1);
                end
            end
            StWaitLo: begin
                if (!lcd_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: head fields held for the whole transfer, all zero while idle.
    always_comb begin
        lcd_start_update = (state_q == StIssue);
        lcd_mode_splash  = 1'b0;
        lcd_mode_blank   = 1'b0;
        lcd_opcode       = '0;
        lcd_reg_idx      = '0;
        lcd_value        = '0;
        if (state_q != StIdle) begin
            if (splash_active) begin
                lcd_mode_splash = 1'b1;
            end else begin
                lcd_mode_blank = head.blank;
                lcd_opcode     = head.opcode;
                lcd_reg_idx    = head.reg_idx;
                lcd_value      = head.value;
            end
        end
    end

endmodule

// File: tb/tb_display_update_queue.sv
// Self-checking bench for display_update_queue: directed scenarios plus a randomized run
// against a queue-level reference model.
module tb_display_update_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUBI = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        lcd_busy;
    logic        lcd_start_update;
    logic        lcd_mode_splash;
    logic        lcd_mode_blank;
    logic [2:0]  lcd_opcode;
    logic [3:0]  lcd_reg_idx;
    logic [15:0] lcd_value;
    logic [4:0]  q_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    display_update_queue_if dq_if ();

    display_update_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (dq_if),
        .flush            (flush),
        .lcd_busy         (lcd_busy),
        .lcd_start_update (lcd_start_update),
        .lcd_mode_splash  (lcd_mode_splash),
        .lcd_mode_blank   (lcd_mode_blank),
        .lcd_opcode       (lcd_opcode),
        .lcd_reg_idx      (lcd_reg_idx),
        .lcd_value        (lcd_value),
        .q_count          (q_count),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lcd_word();
        return {lcd_mode_blank, lcd_opcode, lcd_reg_idx, lcd_value};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [23:0] e);
        dq_if.req_valid   = v;
        dq_if.req_blank   = e[23];
        dq_if.req_opcode  = e[22:20];
        dq_if.req_reg_idx = e[19:16];
        dq_if.req_value   = e[15:0];
    endtask

    // Waits (bounded) for a start pulse, captures {splash, entry}, then completes the handshake.
    task automatic serve_xfer(output logic got, output logic [24:0] seen);
        got = 1'b0;
        seen = '0;
        lcd_busy = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (lcd_start_update) begin
                got = 1'b1;
                seen = {lcd_mode_splash, lcd_word()};
            end
        end
        if (got) begin
            step();
            lcd_busy = 1'b1;
            step();
            step();
            lcd_busy = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        logic got;
        logic [24:0] w;
        rst = 1'b1;
        flush = 1'b0;
        lcd_busy = 1'b0;
        set_req(1'b0, '0);
        step();
        step();
        rst = 1'b0;
`ifdef DISP_Q_SPLASH_EN
        serve_xfer(got, w);
`endif
    endtask

    task automatic test_reset();
        logic got;
        do_reset();
        set_req(1'b1, {1'b0, OP_ADD, 4'h2, 16'h0042});
        step();
        set_req(1'b0, '0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = lcd_start_update;
        end
        checks++; if (!got) begin errors++; $display("FAIL reset_pre_pulse got=0 want=1"); end
        step();
        lcd_busy = 1'b1;
        step();
        rst = 1'b1;
        step();
        checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", q_count); end
        checks++; if (dq_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", dq_if.req_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if ({lcd_start_update, lcd_mode_splash, lcd_word()} !== 26'd0) begin
            errors++; $display("FAIL reset_lcd_outputs got=%h want=0", {lcd_start_update, lcd_mode_splash, lcd_word()});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (lcd_start_update !== 1'b0) begin errors++; $display("FAIL reset_no_pulse got=1 want=0 cyc=%0d", i); end
        end
        lcd_busy = 1'b0;
    endtask

    task automatic test_single();
        logic [23:0] e;
        e = {1'b0, OP_ADD, 4'b0011, 16'd123};
        do_reset();
        set_req(1'b1, e);
        step();
        set_req(1'b0, '0);
        checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL single_count_push got=%0d want=1", q_count); end
        checks++; if (lcd_start_update !== 1'b0) begin errors++; $display("FAIL single_early_pulse got=1 want=0"); end
        step();
        checks++; if (lcd_start_update !== 1'b1) begin errors++; $display("FAIL single_pulse got=0 want=1"); end
        checks++; if (lcd_word() !== e) begin errors++; $display("FAIL single_fields got=%h want=%h", lcd_word(), e); end
        for (int i = 0; i < 5; i++) begin
            lcd_busy = (i >= 2);
            step();
            checks++; if (lcd_start_update !== 1'b0) begin errors++; $display("FAIL single_extra_pulse got=1 want=0 cyc=%0d", i); end
            checks++; if (lcd_word() !== e) begin errors++; $display("FAIL single_hold got=%h want=%h cyc=%0d", lcd_word(), e, i); end
            checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL single_count_hold got=%0d want=1 cyc=%0d", q_count, i); end
        end
        lcd_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL single_count_pop got=%0d want=0 cyc=%0d", q_count, i); end
            checks++; if ({lcd_start_update, lcd_word()} !== 25'd0) begin
                errors++; $display("FAIL single_idle_out got=%h want=0 cyc=%0d", {lcd_start_update, lcd_word()}, i);
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic [23:0] vals [5];
        logic        got;
        logic [24:0] w;
        do_reset();
        lcd_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vals[i] = 24'($urandom);
            set_req(1'b1, vals[i]);
            step();
            if (i == 3) begin
                checks++; if (dq_if.req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", dq_if.req_ready); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_early_ovf got=%b want=0", overflow); end
            end
        end
        set_req(1'b0, '0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b want=1", overflow); end
        checks++; if (q_count !== 5'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", q_count); end
        for (int i = 0; i < 4; i++) begin
            serve_xfer(got, w);
            checks++; if (!got || w !== {1'b0, vals[i]}) begin
                errors++; $display("FAIL fill_drain_order got=%h want=%h idx=%0d", w, {1'b0, vals[i]}, i);
            end
        end
        checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL fill_drained got=%0d want=0", q_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_negative();
        logic [23:0] e;
        logic        got;
        e = {1'b0, OP_SUBI, 4'b1111, 16'h8000};
        do_reset();
        set_req(1'b1, e);
        step();
        set_req(1'b0, '0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = lcd_start_update;
        end
        checks++; if (!got) begin errors++; $display("FAIL neg_pulse got=0 want=1"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (lcd_word() !== e) begin errors++; $display("FAIL neg_value got=%h want=%h cyc=%0d", lcd_word(), e, i); end
            lcd_busy = (i >= 1 && i <= 2);
            step();
        end
        checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL neg_pop got=%0d want=0", q_count); end
        lcd_busy = 1'b0;
    endtask

    task automatic test_timeout();
        logic [23:0] e;
        logic        got;
        logic        exp_pulse;
        e = {1'b1, 3'b110, 4'h5, 16'h1234};
        do_reset();
        set_req(1'b1, e);
        step();
        set_req(1'b0, '0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = lcd_start_update;
        end
        checks++; if (!got) begin errors++; $display("FAIL timeout_first_pulse got=0 want=1"); end
        // Busy rises at cycle 27 (after the pulse at 24), falls at 34 to complete the transfer.
        for (int k = 1; k <= 36; k++) begin
            lcd_busy = (k >= 27 && k <= 33);
            step();
            exp_pulse = (k < 27) && (k % 8 == 0);
            checks++; if (lcd_start_update !== exp_pulse) begin
                errors++; $display("FAIL timeout_pulse got=%b want=%b k=%0d", lcd_start_update, exp_pulse, k);
            end
            checks++; if (q_count !== ((k < 34) ? 5'd1 : 5'd0)) begin
                errors++; $display("FAIL timeout_count got=%0d k=%0d", q_count, k);
            end
            if (k < 34) begin
                checks++; if (lcd_word() !== e) begin errors++; $display("FAIL timeout_hold got=%h want=%h k=%0d", lcd_word(), e, k); end
            end
        end
        lcd_busy = 1'b0;
    endtask

    task automatic test_flush();
        logic [23:0] vals [3];
        logic        got;
        int          pulses;
        do_reset();
        lcd_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vals[i] = 24'($urandom);
            set_req(1'b1, vals[i]);
            step();
        end
        set_req(1'b0, '0);
        lcd_busy = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            got = lcd_start_update;
        end
        checks++; if (!got) begin errors++; $display("FAIL flush_pulse got=0 want=1"); end
        step();
        lcd_busy = 1'b1;
        step();
        checks++; if (q_count !== 5'd3) begin errors++; $display("FAIL flush_pre_count got=%0d want=3", q_count); end
        flush = 1'b1;
        set_req(1'b1, 24'($urandom));
        step();
        flush = 1'b0;
        set_req(1'b0, '0);
        checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL flush_keep_head got=%0d want=1", q_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%b want=0", overflow); end
        checks++; if (lcd_word() !== vals[0]) begin errors++; $display("FAIL flush_head_held got=%h want=%h", lcd_word(), vals[0]); end
        lcd_busy = 1'b0;
        step();
        checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", q_count); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (lcd_start_update) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_pulse got=%0d want=0", pulses); end
    endtask

    task automatic test_splash();
        logic [23:0] e;
        logic        got;
        logic [24:0] w;
        e = {1'b0, 3'b111, 4'h9, 16'hBEEF};
        rst = 1'b1;
        flush = 1'b0;
        lcd_busy = 1'b0;
        set_req(1'b0, '0);
        step();
        step();
        rst = 1'b0;
        set_req(1'b1, e);
        step();
        set_req(1'b0, '0);
        checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL splash_count got=%0d want=1", q_count); end
`ifdef DISP_Q_SPLASH_EN
        checks++; if ({lcd_start_update, lcd_mode_splash, lcd_word()} !== {2'b11, 24'd0}) begin
            errors++; $display("FAIL splash_first got=%h", {lcd_start_update, lcd_mode_splash, lcd_word()});
        end
        step();
        lcd_busy = 1'b1;
        step();
        lcd_busy = 1'b0;
        step();
        checks++; if (q_count !== 5'd1) begin errors++; $display("FAIL splash_no_slot got=%0d want=1", q_count); end
        serve_xfer(got, w);
        checks++; if (!got || w !== {1'b0, e}) begin errors++; $display("FAIL splash_then_entry got=%h want=%h", w, {1'b0, e}); end
`else
        checks++; if (lcd_start_update !== 1'b0) begin errors++; $display("FAIL nosplash_early got=1 want=0"); end
        serve_xfer(got, w);
        checks++; if (!got || w !== {1'b0, e}) begin errors++; $display("FAIL nosplash_first got=%h want=%h", w, {1'b0, e}); end
`endif
        checks++; if (q_count !== 5'd0) begin errors++; $display("FAIL splash_drained got=%0d want=0", q_count); end
    endtask

    task automatic test_random();
        logic [23:0] mq [$];
        logic        mov;
        logic        in_xfer;
        logic        do_pop;
        logic        acc;
        logic [23:0] e;
        int          pre_cnt;
        int          hi_cnt;
        do_reset();
        mq.delete();
        mov = 1'b0;
        in_xfer = 1'b0;
        pre_cnt = 0;
        hi_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (q_count !== 5'(mq.size())) begin
                errors++; $display("FAIL rand_count got=%0d want=%0d cyc=%0d", q_count, mq.size(), cyc);
            end
            checks++; if (dq_if.req_ready !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready got=%b cyc=%0d", dq_if.req_ready, cyc);
            end
            checks++; if (overflow !== mov) begin errors++; $display("FAIL rand_overflow got=%b want=%b cyc=%0d", overflow, mov, cyc); end
            if (lcd_start_update) begin
                checks++; if (in_xfer || mq.size() == 0) begin
                    errors++; $display("FAIL rand_pulse got=1 want=0 cyc=%0d", cyc);
                end else begin
                    in_xfer = 1'b1;
                    pre_cnt = 1 + int'($urandom_range(0, 4));
                    hi_cnt = int'($urandom_range(1, 4));
                end
            end
            if (in_xfer) begin
                checks++; if ({lcd_mode_splash, lcd_word()} !== {1'b0, mq[0]}) begin
                    errors++; $display("FAIL rand_fields got=%h want=%h cyc=%0d", {lcd_mode_splash, lcd_word()}, mq[0], cyc);
                end
            end else begin
                checks++; if ({lcd_start_update, lcd_mode_splash, lcd_word()} !== 26'd0) begin
                    errors++; $display("FAIL rand_idle_out got=%h want=0 cyc=%0d", lcd_word(), cyc);
                end
            end
            // LCD controller: quiet through the start edge, then busy for a while, then done.
            do_pop = 1'b0;
            if (in_xfer) begin
                if (pre_cnt > 0) begin
                    lcd_busy = 1'b0;
                    pre_cnt--;
                end else if (hi_cnt > 0) begin
                    lcd_busy = 1'b1;
                    hi_cnt--;
                end else begin
                    lcd_busy = 1'b0;
                    do_pop = 1'b1;
                end
            end else begin
                lcd_busy = 1'b0;
            end
            e = 24'($urandom);
            acc = 1'b0;
            if ($urandom_range(0, 99) < 45) begin
                set_req(1'b1, e);
                if (mq.size() < DEPTH) acc = 1'b1;
                else mov = 1'b1;
            end else begin
                set_req(1'b0, e);
            end
            if (do_pop) begin
                void'(mq.pop_front());
                in_xfer = 1'b0;
            end
            if (acc) mq.push_back(e);
            step();
        end
        set_req(1'b0, '0);
        lcd_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_negative();
        test_timeout();
        test_flush();
        test_splash();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
